// File: rtl/jtag_switch_pkg.sv
// Shared types and idle levels for the JTAG channel switch.
// The idle levels are shared by the reset values, PARK and the reset sequence.
package jtag_switch_pkg;

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_PARK,
    ST_RSTSEQ,
    ST_HANDOVER
  } sw_state_t;

  localparam logic IDLE_TCK    = 1'b0;
  localparam logic IDLE_TMS    = 1'b1;
  localparam logic IDLE_TDI    = 1'b0;
  localparam logic IDLE_TRST_N = 1'b1;
  localparam logic RST_TRST_N  = 1'b0;

endpackage

// File: rtl/jtag_tck_seq_gen.sv
// Generates NUM_PULSES TCK pulses, each HALF_PERIOD low then HALF_PERIOD high,
// followed by a trailing HALF_PERIOD low phase. done pulses in the final cycle.
module jtag_tck_seq_gen #(
  parameter int NUM_PULSES  = 5,
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic tck,
  output logic done
);

  localparam int PH_LAST = 2 * NUM_PULSES;
  localparam int PH_W    = $clog2(PH_LAST + 2);
  localparam int HC_W    = $clog2(HALF_PERIOD + 1);

  logic            running_reg;
  logic [PH_W-1:0] phase_reg;
  logic [HC_W-1:0] half_cnt_reg;
  logic            half_end;

  assign half_end = (half_cnt_reg == HC_W'(HALF_PERIOD - 1));
  assign done     = running_reg && half_end && (phase_reg == PH_W'(PH_LAST));
  // Odd phases are the high halves; phase 0 and the last phase are low.
  assign tck      = running_reg && phase_reg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_reg  <= 1'b0;
      phase_reg    <= '0;
      half_cnt_reg <= '0;
    end else if (start && !running_reg) begin
      running_reg  <= 1'b1;
      phase_reg    <= '0;
      half_cnt_reg <= '0;
    end else if (running_reg) begin
      if (half_end) begin
        half_cnt_reg <= '0;
        if (phase_reg == PH_W'(PH_LAST)) begin
          running_reg <= 1'b0;
        end else begin
          phase_reg <= phase_reg + PH_W'(1);
        end
      end else begin
        half_cnt_reg <= half_cnt_reg + HC_W'(1);
      end
    end
  end

endmodule

// File: rtl/jtag_channel_switch.sv
// N-channel JTAG source selector with glitch-free switchover:
// drain old TCK, park, optional TAP reset walk, then hand over to the new channel.
module jtag_channel_switch
  import jtag_switch_pkg::*;
#(
  parameter int               NUM_CH          = 2,
  parameter int               SEL_W           = $clog2(NUM_CH),
  parameter int               DEFAULT_CH      = 0,
  parameter int               SYNC_STAGES     = 2,
  parameter bit               RESET_ON_SWITCH = 1'b1,
  parameter int               TAP_RST_CLKS    = 5,
  parameter int               HALF_PERIOD     = 4,
  parameter int               DRAIN_TIMEOUT   = 64,
  parameter int               CNT_W           = 16,
  parameter logic [NUM_CH-1:0] CH_HAS_TRST    = NUM_CH'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  ch_sel_req,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [NUM_CH-1:0] ch_tck,
  input  logic [NUM_CH-1:0] ch_tms,
  input  logic [NUM_CH-1:0] ch_tdi,
  input  logic [NUM_CH-1:0] ch_trst_n,
  output logic [NUM_CH-1:0] ch_tdo,
  output logic              jtag_clk,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  output logic              jtag_rst_n,
  input  logic              jtag_tdo,
  output logic [SEL_W-1:0]  active_ch,
  output logic              switch_busy,
  output logic              sel_error,
  output logic [CNT_W-1:0]  switch_count
);

  localparam int             DC_W     = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [SEL_W:0] NUM_CH_V = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] s_tck, s_tms, s_tdi, s_trst_n;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] tck_pipe, tms_pipe, tdi_pipe, trst_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tck_pipe  <= {SYNC_STAGES{IDLE_TCK}};
          tms_pipe  <= {SYNC_STAGES{IDLE_TMS}};
          tdi_pipe  <= {SYNC_STAGES{IDLE_TDI}};
          trst_pipe <= {SYNC_STAGES{IDLE_TRST_N}};
        end else begin
          tck_pipe  <= {tck_pipe[SYNC_STAGES-2:0], ch_tck[gi]};
          tms_pipe  <= {tms_pipe[SYNC_STAGES-2:0], ch_tms[gi]};
          tdi_pipe  <= {tdi_pipe[SYNC_STAGES-2:0], ch_tdi[gi]};
          trst_pipe <= {trst_pipe[SYNC_STAGES-2:0], ch_trst_n[gi]};
        end
      end

      assign s_tck[gi]    = tck_pipe[SYNC_STAGES-1];
      assign s_tms[gi]    = tms_pipe[SYNC_STAGES-1];
      assign s_tdi[gi]    = tdi_pipe[SYNC_STAGES-1];
      assign s_trst_n[gi] = trst_pipe[SYNC_STAGES-1];
    end
  endgenerate

  sw_state_t        state_reg;
  logic [SEL_W-1:0] active_reg, target_reg;
  logic [DC_W-1:0]  drain_cnt_reg;
  logic             req_valid;
  logic             seq_start, seq_tck, seq_done;

  assign req_valid = ({1'b0, ch_sel_req} < NUM_CH_V) && ch_enable[ch_sel_req];
  assign seq_start = (state_reg == ST_PARK) && RESET_ON_SWITCH;
  assign active_ch = active_reg;

  jtag_tck_seq_gen #(
    .NUM_PULSES  (TAP_RST_CLKS),
    .HALF_PERIOD (HALF_PERIOD)
  ) u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (seq_start),
    .tck   (seq_tck),
    .done  (seq_done)
  );

  // TDO is only returned to the owning channel while routing is live.
  always_comb begin
    ch_tdo = '0;
    if (state_reg == ST_ACTIVE) ch_tdo[active_reg] = jtag_tdo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_ACTIVE;
      active_reg    <= SEL_W'(DEFAULT_CH);
      target_reg    <= SEL_W'(DEFAULT_CH);
      drain_cnt_reg <= '0;
      jtag_clk      <= IDLE_TCK;
      jtag_tms      <= IDLE_TMS;
      jtag_tdi      <= IDLE_TDI;
      jtag_rst_n    <= RST_TRST_N;
      switch_busy   <= 1'b0;
      sel_error     <= 1'b0;
      switch_count  <= '0;
    end else begin
      sel_error <= !req_valid;
      case (state_reg)
        ST_ACTIVE: begin
          jtag_clk   <= s_tck[active_reg];
          jtag_tms   <= s_tms[active_reg];
          jtag_tdi   <= s_tdi[active_reg];
          jtag_rst_n <= CH_HAS_TRST[active_reg] ? s_trst_n[active_reg] : IDLE_TRST_N;
          if (req_valid && (ch_sel_req != active_reg)) begin
            target_reg    <= ch_sel_req;
            drain_cnt_reg <= '0;
            switch_busy   <= 1'b1;
            state_reg     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Outputs hold; wait for the old TCK to be low so the last pulse is not cut short.
          if (!s_tck[active_reg] || (drain_cnt_reg == DC_W'(DRAIN_TIMEOUT - 1))) begin
            state_reg <= ST_PARK;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DC_W'(1);
          end
        end
        ST_PARK: begin
          jtag_clk  <= IDLE_TCK;
          jtag_tms  <= IDLE_TMS;
          jtag_tdi  <= IDLE_TDI;
          state_reg <= RESET_ON_SWITCH ? ST_RSTSEQ : ST_HANDOVER;
        end
        ST_RSTSEQ: begin
          jtag_clk   <= seq_tck;
          jtag_tms   <= IDLE_TMS;
          jtag_tdi   <= IDLE_TDI;
          jtag_rst_n <= IDLE_TRST_N;
          if (seq_done) state_reg <= ST_HANDOVER;
        end
        ST_HANDOVER: begin
          active_reg  <= target_reg;
          switch_busy <= 1'b0;
          state_reg   <= ST_ACTIVE;
          if (switch_count != '1) switch_count <= switch_count + CNT_W'(1);
        end
        default: state_reg <= ST_ACTIVE;
      endcase
    end
  end

endmodule
